// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// with divide-by-zero short path and in-flight cancellation.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        neg1_q,     neg1_d;
    logic        neg2_q,     neg2_d;
    logic [63:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    logic [32:0] diff;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg1_d     = neg1_q;
        neg2_d     = neg2_q;
        result_d   = result_q;
        ready_d    = ready_q;

        diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
        abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

        // Quotient sign follows the operand signs, remainder follows the dividend
        quot = dividend_q[31:0];
        rem  = dividend_q[64:33];
        if (neg1_q ^ neg2_q) quot = ~quot + 32'd1;
        if (neg1_q)          rem  = ~rem + 32'd1;

        unique case (state_q)
            ST_FREE: begin
                ready_d  = 1'b0;
                result_d = 64'd0;
                if (start_i && !annul_i) begin
                    neg1_d    = signed_div_i & opdata1_i[31];
                    neg2_d    = signed_div_i & opdata2_i[31];
                    divisor_d = abs2;
                    if (opdata2_i == 32'd0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d    = ST_ON;
                        cnt_d      = 6'd0;
                        dividend_d = {32'd0, abs1, 1'b0};
                    end
                end
            end
            ST_BYZERO: begin
                state_d  = ST_END;
                result_d = 64'd0;
                ready_d  = 1'b1;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else if (cnt_q != 6'd32) begin
                    if (diff[32]) dividend_d = {dividend_q[63:0], 1'b0};
                    else          dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = ST_END;
                    cnt_d    = 6'd0;
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
